// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the excitation function used by JK-based counters.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // {J,K} that moves a cell from cur to nxt; don't-cares resolve to 0, so toggle never appears.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage

// File: rtl/jk_ff_rst.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jk_ff_rst
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic nQ
);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_HOLD:   Q <= Q;
                JK_RESET:  Q <= 1'b0;
                JK_SET:    Q <= 1'b1;
                JK_TOGGLE: Q <= ~Q;
                default:   Q <= Q;
            endcase
        end
    end

    assign nQ = ~Q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD synchronous up/down counter: next-state mux drives per-bit JK excitation
// into a bank of JK cells, with a registered wrap pulse.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             wrap
);

    // Comparisons are done in WIDTH+1 bits so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W = MOD[WIDTH:0];
    localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_d;
    logic             wrap_q;

    assign q_ext = {1'b0, q};
    assign sum   = q_ext + 1'b1;

    always_comb begin
        nxt    = q;
        wrap_d = 1'b0;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            if ({1'b0, d} >= MOD_W) begin
                nxt = MAX_W[WIDTH-1:0];
            end else begin
                nxt = d;
            end
        end else if (en) begin
            if (q_ext >= MOD_W) begin
                nxt = '0;
            end else if (up_dn) begin
                if (q_ext == MAX_W) begin
                    nxt    = '0;
                    wrap_d = 1'b1;
                end else begin
                    nxt = sum[WIDTH-1:0];
                end
            end else begin
                if (q == '0) begin
                    nxt    = MAX_W[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    nxt = q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (rst) begin
                {j[i], k[i]} = JK_RESET;
            end else begin
                {j[i], k[i]} = jk_excite(q[i], nxt[i]);
            end
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_ff_rst u_cell (
            .clk (clk),
            .rst (rst),
            .J   (j[g]),
            .K   (k[g]),
            .Q   (q[g]),
            .nQ  (q_n[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
    assign tc   = en & (up_dn ? (q_ext == MAX_W) : (q == '0));

endmodule
